// File: rtl/traffic_light_ctrl.sv
// Two-way intersection sequencer with pedestrian shortening and night flash.
// Phases are timed in whole seconds from an internal prescaler.
module traffic_light_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int G_TIME   = 30,
  parameter int Y_TIME   = 3,
  parameter int R_TIME   = 2,
  parameter int PED_MIN  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night_en,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] cnt_bcd,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_EW = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0] G_T = 7'(G_TIME);
  localparam logic [6:0] Y_T = 7'(Y_TIME);
  localparam logic [6:0] R_T = 7'(R_TIME);
  localparam logic [6:0] P_M = 7'(PED_MIN);

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  state_t        state, state_n;
  logic [6:0]    rem, rem_n;
  logic [PW-1:0] psc, psc_n;
  logic          pend, pend_n;
  logic          fl_on, fl_on_n;
  logic          tick, green;
  logic [2:0]    ns_n, ew_n;
  logic [7:0]    cnt_n;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 7'd10);
    u = 4'(v % 7'd10);
    return {t, u};
  endfunction

  function automatic logic [6:0] dur(input state_t s);
    unique case (s)
      NS_G, EW_G: return G_T;
      NS_Y, EW_Y: return Y_T;
      default:    return R_T;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    unique case (s)
      AR_NS:   return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return AR_EW;
      AR_EW:   return EW_G;
      EW_G:    return EW_Y;
      default: return AR_NS;
    endcase
  endfunction

  always_comb begin
    tick    = (psc == PS_MAX);
    green   = (state == NS_G) || (state == EW_G);
    state_n = state;
    rem_n   = rem;
    psc_n   = tick ? '0 : psc + 1'b1;
    pend_n  = pend | ped_req;
    fl_on_n = fl_on;
    if (state == FLASH) begin
      pend_n = 1'b0;
      if (!night_en)
        state_n = AR_NS;
      else if (tick)
        fl_on_n = ~fl_on;
    end else if (night_en) begin
      state_n = FLASH;
      pend_n  = 1'b0;
      fl_on_n = 1'b1;
    end else if (green && pend && rem > P_M) begin
      // shortening wins over a coincident tick; prescaler phase is kept
      rem_n  = P_M;
      pend_n = ped_req;
    end else begin
      if (green && pend)
        pend_n = ped_req;
      if (tick) begin
        if (rem == 7'd1)
          state_n = succ(state);
        else
          rem_n = rem - 7'd1;
      end
    end
    if (state_n != state) begin
      psc_n = '0;
      rem_n = dur(state_n);
    end
  end

  always_comb begin
    ns_n  = L_R;
    ew_n  = L_R;
    cnt_n = to_bcd(rem_n);
    unique case (state_n)
      NS_G: ns_n = L_G;
      NS_Y: ns_n = L_Y;
      EW_G: ew_n = L_G;
      EW_Y: ew_n = L_Y;
      FLASH: begin
        ns_n  = fl_on_n ? L_Y : 3'b000;
        ew_n  = fl_on_n ? L_Y : 3'b000;
        cnt_n = 8'hFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= AR_NS;
      rem      <= R_T;
      psc      <= '0;
      pend     <= 1'b0;
      fl_on    <= 1'b1;
      ns_light <= L_R;
      ew_light <= L_R;
      cnt_bcd  <= to_bcd(R_T);
      phase    <= 3'd0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      psc      <= psc_n;
      pend     <= pend_n;
      fl_on    <= fl_on_n;
      ns_light <= ns_n;
      ew_light <= ew_n;
      cnt_bcd  <= cnt_n;
      phase    <= state_n;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed vector table plus randomized run against a deadline-based model
// of the intersection timing.
module tb_traffic_light_ctrl;

  localparam int TD = 4;
  localparam int GT = 6;
  localparam int YT = 2;
  localparam int RT = 1;
  localparam int PM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_en = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic [7:0] cnt_bcd;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .TICK_DIV(TD), .G_TIME(GT), .Y_TIME(YT),
    .R_TIME(RT), .PED_MIN(PM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ped_req(ped_req), .night_en(night_en),
    .ns_light(ns_light), .ew_light(ew_light),
    .cnt_bcd(cnt_bcd), .phase(phase)
  );

  typedef struct {
    logic       ped;
    logic       night;
    int         n;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [7:0] cnt;
    logic [2:0] ph;
  } vec_t;

  vec_t tbl[$];

  // model: phase index, entry cycle, deadline cycle
  int now, t0, tend, mph;
  bit pend;

  function automatic int dur(int p);
    if (p == 0 || p == 3) return RT;
    if (p == 1 || p == 4) return GT;
    if (p == 2 || p == 5) return YT;
    return 0;
  endfunction

  function automatic void m_enter(int p);
    mph = p;
    t0 = now;
    tend = now + dur(p) * TD;
  endfunction

  function automatic void m_reset();
    now = 0;
    pend = 0;
    m_enter(0);
  endfunction

  function automatic int m_rem();
    return (tend - now + TD - 1) / TD;
  endfunction

  function automatic void m_edge(logic p, logic nt);
    int rp;
    bit grn, sh;
    rp = m_rem();
    grn = (mph == 1 || mph == 4);
    now++;
    if (mph == 6) begin
      pend = 0;
      if (!nt) m_enter(0);
    end else if (nt) begin
      pend = 0;
      m_enter(6);
    end else begin
      sh = grn && pend && rp > PM;
      if (grn && pend) pend = 0;
      if (sh)
        tend = now + PM * TD - ((now - t0) % TD);
      else if (now == tend)
        m_enter((mph + 1) % 6);
      if (p) pend = 1;
    end
  endfunction

  function automatic logic [16:0] m_exp();
    logic [2:0] ns, ew;
    logic [7:0] c;
    int r;
    ns = 3'b100;
    ew = 3'b100;
    r = m_rem();
    c = {4'(r / 10), 4'(r % 10)};
    case (mph)
      1: ns = 3'b001;
      2: ns = 3'b010;
      4: ew = 3'b001;
      5: ew = 3'b010;
      6: begin
        ns = (((now - t0) / TD) % 2 == 0) ? 3'b010 : 3'b000;
        ew = ns;
        c = 8'hFF;
      end
      default: ;
    endcase
    return {ns, ew, c, 3'(mph)};
  endfunction

  function automatic logic [16:0] outs();
    return {ns_light, ew_light, cnt_bcd, phase};
  endfunction

  task automatic check(string nm, logic [16:0] got, logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ns=%b ew=%b cnt=%h ph=%0d want ns=%b ew=%b cnt=%h ph=%0d",
               nm, got[16:14], got[13:11], got[10:3], got[2:0],
               exp[16:14], exp[13:11], exp[10:3], exp[2:0]);
    end
  endtask

  task automatic step(logic p, logic nt);
    ped_req = p;
    night_en = nt;
    @(posedge clk);
    m_edge(p, nt);
    @(negedge clk);
    ped_req = 1'b0;
  endtask

  function automatic void add(logic p, logic nt, int n, logic [2:0] ns,
                              logic [2:0] ew, logic [7:0] c, logic [2:0] ph);
    vec_t v;
    v.ped = p; v.night = nt; v.n = n;
    v.ns = ns; v.ew = ew; v.cnt = c; v.ph = ph;
    tbl.push_back(v);
  endfunction

  localparam logic [16:0] RST_V = {3'b100, 3'b100, 8'h01, 3'd0};

  initial begin
    // power-up, free run
    add(0, 0,  3, 3'b100, 3'b100, 8'h01, 0);
    add(0, 0,  1, 3'b001, 3'b100, 8'h06, 1);
    add(0, 0,  4, 3'b001, 3'b100, 8'h05, 1);
    add(0, 0, 19, 3'b001, 3'b100, 8'h01, 1);
    add(0, 0,  1, 3'b010, 3'b100, 8'h02, 2);
    add(0, 0,  8, 3'b100, 3'b100, 8'h01, 3);
    add(0, 0,  4, 3'b100, 3'b001, 8'h06, 4);
    add(0, 0, 24, 3'b100, 3'b010, 8'h02, 5);
    add(0, 0,  8, 3'b100, 3'b100, 8'h01, 0);
    add(0, 0,  4, 3'b001, 3'b100, 8'h06, 1);
    // pedestrian in NS_G
    add(1, 0,  1, 3'b001, 3'b100, 8'h06, 1);
    add(0, 0,  1, 3'b001, 3'b100, 8'h03, 1);
    add(0, 0,  9, 3'b001, 3'b100, 8'h01, 1);
    add(0, 0,  1, 3'b010, 3'b100, 8'h02, 2);
    // pedestrian during NS_Y held until EW_G
    add(1, 0,  1, 3'b010, 3'b100, 8'h02, 2);
    add(0, 0,  7, 3'b100, 3'b100, 8'h01, 3);
    add(0, 0,  4, 3'b100, 3'b001, 8'h06, 4);
    add(0, 0,  1, 3'b100, 3'b001, 8'h03, 4);
    add(0, 0, 10, 3'b100, 3'b001, 8'h01, 4);
    add(0, 0,  1, 3'b100, 3'b010, 8'h02, 5);
    // night mode mid EW_G
    add(0, 0,  8, 3'b100, 3'b100, 8'h01, 0);
    add(0, 0,  4, 3'b001, 3'b100, 8'h06, 1);
    add(0, 0, 24, 3'b010, 3'b100, 8'h02, 2);
    add(0, 0,  8, 3'b100, 3'b100, 8'h01, 3);
    add(0, 0,  4, 3'b100, 3'b001, 8'h06, 4);
    add(0, 0,  5, 3'b100, 3'b001, 8'h05, 4);
    add(0, 1,  1, 3'b010, 3'b010, 8'hFF, 6);
    add(1, 1,  3, 3'b010, 3'b010, 8'hFF, 6);
    add(0, 1,  1, 3'b000, 3'b000, 8'hFF, 6);
    add(0, 1,  4, 3'b010, 3'b010, 8'hFF, 6);
    add(0, 0,  1, 3'b100, 3'b100, 8'h01, 0);
    add(0, 0,  4, 3'b001, 3'b100, 8'h06, 1);

    m_reset();
    repeat (2) @(negedge clk);
    check("reset_hold", outs(), RST_V);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].ped, tbl[i].night);
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].ns, tbl[i].ew, tbl[i].cnt, tbl[i].ph});
    end

    // async reset mid NS_Y
    repeat (24) step(0, 0);
    check("ns_y_before_rst", outs(), {3'b010, 3'b100, 8'h02, 3'd2});
    repeat (3) step(0, 0);
    #2 rst_n = 1'b0;
    #1 check("async_rst", outs(), RST_V);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (3) step(0, 0);
    check("rst_ar_ns", outs(), RST_V);
    step(0, 0);
    check("rst_ns_g", outs(), {3'b001, 3'b100, 8'h06, 3'd1});

    // randomized run against the model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    begin
      logic nt;
      logic p;
      nt = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(59) == 0) nt = ~nt;
        p = ($urandom_range(9) == 0);
        if ($urandom_range(499) == 0) begin
          #2 rst_n = 1'b0;
          #1 check("rand_rst", outs(), RST_V);
          @(negedge clk);
          rst_n = 1'b1;
          m_reset();
        end
        step(p, nt);
        check("rand", outs(), m_exp());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
